arb_mux_reg: RTL and testbench

//  Parametrised, registered N:1 channel mux with built-in arbitration and valid/ready handshake.

---
 rtl/arb_mux_reg.sv | 69 ++++++
 tb/tb_arb_mux_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: registered N:1 arbitrated mux with valid/ready handshake; define ARB_MUX_ROUND_ROBIN_EN for round-robin, else fixed priority
module arb_mux_reg #(
  parameter int NUM_CH = 32,
  parameter int DATA_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_sel,
  input  logic                       out_ready
);
  localparam int SEL_W = $clog2(NUM_CH);
  logic              w_accept;
  logic              w_found;
  logic              w_go;
  logic [SEL_W-1:0]  w_start;
  logic [SEL_W-1:0]  w_win;
  logic [SEL_W:0]    w_idx;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  assign w_accept = !r_valid || out_ready;
  assign w_go     = !rst && w_accept && w_found;
  assign in_ready = w_go ? {{(NUM_CH-1){1'b0}}, 1'b1} << w_win : '0;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
`ifdef ARB_MUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0] r_ptr;
  assign w_start = r_ptr;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (w_go) r_ptr <= (w_win == SEL_W'(NUM_CH-1)) ? '0 : w_win + 1'b1;
`else
  assign w_start = '0;
`endif
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_data  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, w_start} + (SEL_W+1)'(k);
      w_idx = (w_idx >= (SEL_W+1)'(NUM_CH)) ? w_idx - (SEL_W+1)'(NUM_CH) : w_idx;
      if (!w_found && in_valid[w_idx[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[SEL_W-1:0];
        w_data  = in_data[int'(w_idx[SEL_W-1:0])*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_data;
        r_sel  <= w_win;
      end
    end
endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: directed and random checks of arb_mux_reg against a reference model
module tb_arb_mux_reg;
  localparam int N = 32, W = 20;
`ifdef ARB_MUX_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [4:0]     out_sel;
  logic           out_ready = 1'b0;
  logic [4:0]     in_valid5 = '1;
  logic [4:0]     in_ready5;
  logic [39:0]    in_data5 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
  logic           out_valid5;
  logic [7:0]     out_data5;
  logic [2:0]     out_sel5;
  arb_mux_reg #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready));
  arb_mux_reg #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_sel(out_sel5), .out_ready(1'b1));
  int checks = 0;
  int errors = 0;
  bit m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int m_sel = 0;
  int m_ptr = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int winner();
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (in_valid[i]) begin
        int d = RR ? (i - m_ptr + N) % N : i;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    return best;
  endfunction
  task automatic step(input string tag);
    int w;
    bit acc;
    logic [N-1:0] er;
    #1;
    acc = !m_valid || out_ready;
    w = winner();
    er = (!rst && acc && w >= 0) ? (N'(1) << w) : '0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data = '0;
      m_sel = 0;
      m_ptr = 0;
    end else if (acc) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data = in_data[w*W +: W];
        m_sel = w;
        m_ptr = (w + 1) % N;
      end else m_valid = 1'b0;
    end
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, ".out_data"}, 64'(out_data), 64'(m_data));
      chk({tag, ".out_sel"}, 64'(out_sel), 64'(m_sel));
    end
  endtask
  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
  endtask
  int rr_seq[5] = '{0, 3, 31, 0, 3};
  initial begin
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    rand_data();
    step("reset");
    step("reset");
    chk("reset.out_data", 64'(out_data), 64'h0);
    chk("reset.out_sel", 64'(out_sel), 64'h0);
    chk("reset.out_valid5", 64'(out_valid5), 64'h0);
    rst = 1'b0;
    in_valid = '0;
    for (int k = 0; k < 6; k++) begin
      step("idle");
      chk("nc5.out_valid", 64'(out_valid5), 64'h1);
      chk("nc5.out_sel", 64'(out_sel5), RR ? 64'(k % 5) : 64'h0);
      chk("nc5.out_data", 64'(out_data5), RR ? 64'(8'h10 + k % 5) : 64'h10);
    end
    in_valid = 32'h20;
    in_data[5*W +: W] = 20'hABCDE;
    out_ready = 1'b1;
    step("single");
    chk("single.out_sel", 64'(out_sel), 64'd5);
    chk("single.out_data", 64'(out_data), 64'hABCDE);
    in_valid = 32'h6;
    out_ready = 1'b0;
    rand_data();
    for (int k = 0; k < 4; k++) begin
      step("bp");
      chk("bp.out_sel", 64'(out_sel), 64'd5);
      chk("bp.out_data", 64'(out_data), 64'hABCDE);
    end
    out_ready = 1'b1;
    step("bp_release");
    chk("bp_release.out_sel", 64'(out_sel), 64'd1);
    out_ready = 1'b0;
    step("hold");
    rst = 1'b1;
    step("midrst");
    chk("midrst.out_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    in_valid = 32'h8000_0009;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step("rr");
      chk("rr.out_sel", 64'(out_sel), RR ? 64'(rr_seq[k]) : 64'h0);
    end
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom % 50) == 0;
      in_valid = ($urandom % 5 == 0) ? '0 : N'($urandom & $urandom);
      out_ready = ($urandom % 4) != 0;
      rand_data();
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
